// File: rtl/mtpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mtpu_pkg
// Description : Shared defaults and FSM state encoding for the skew buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package mtpu_pkg;

    localparam int c_data_width_default = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/skew_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : skew_buffer_if
// Description : Write/clear/start handshake and skewed output beat bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface skew_buffer_if
    import mtpu_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width_default,
    parameter int LINES      = 4,
    parameter int DEPTH      = 4
);
    localparam int c_line_w = $clog2(LINES);
    localparam int c_elem_w = $clog2(DEPTH);

    logic                        wr_en;
    logic [c_line_w-1:0]         wr_line;
    logic [c_elem_w-1:0]         wr_elem;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic                        clr;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        wr_err;
    logic [LINES-1:0]            out_valid;
    logic [LINES*DATA_WIDTH-1:0] data_out;

    modport master (
        output wr_en, wr_line, wr_elem, wr_data, clr, start,
        input  busy, done, wr_err, out_valid, data_out
    );

    modport slave (
        input  wr_en, wr_line, wr_elem, wr_data, clr, start,
        output busy, done, wr_err, out_valid, data_out
    );

endinterface
`default_nettype wire

// File: rtl/skew_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : skew_ctrl
// Description : Stream FSM, step counter and per-line element index/valid.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_ctrl
    import mtpu_pkg::*;
#(
    parameter int LINES = 4,
    parameter int DEPTH = 4
) (
    input  wire logic                             clk,
    input  wire logic                             rst_n,
    input  wire logic                             start,
    output logic                                  busy,
    output logic                                  last,
    output logic [LINES-1:0]                      lane_valid,
    output logic [LINES*$clog2(DEPTH)-1:0]        lane_elem
);
    localparam int c_steps  = DEPTH + LINES - 1;
    localparam int c_step_w = $clog2(c_steps);
    localparam int c_elem_w = $clog2(DEPTH);

    state_t              r_state;
    logic [c_step_w-1:0] r_step;

    assign busy = (r_state == STREAM);
    assign last = busy && (r_step == c_step_w'(c_steps - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= STREAM;
                        r_step  <= '0;
                    end
                end
                STREAM: begin
                    if (last) begin
                        r_step <= '0;
                        // A start alongside the final beat chains the next stream with no gap.
                        if (!start) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LINES; i++) begin : g_lane
        assign lane_valid[i] = busy
                             && (int'(r_step) >= i)
                             && (int'(r_step) <  i + DEPTH);
        assign lane_elem[i*c_elem_w +: c_elem_w] = c_elem_w'(int'(r_step) - i);
    end

endmodule
`default_nettype wire

// File: rtl/skew_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skew_buffer
// Description : LINES x DEPTH cell array streamed out as a diagonal skewed beat.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_buffer
    import mtpu_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width_default,
    parameter int LINES      = 4,
    parameter int DEPTH      = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    skew_buffer_if.slave bus
);
    localparam int c_elem_w = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]       r_mem [LINES][DEPTH];
    logic [LINES-1:0]            r_out_valid;
    logic [LINES*DATA_WIDTH-1:0] r_data_out;
    logic                        r_done;
    logic                        r_wr_err;

    logic                        w_busy;
    logic                        w_last;
    logic [LINES-1:0]            w_lane_valid;
    logic [LINES*c_elem_w-1:0]   w_lane_elem;
    logic                        w_wr_ok;
    logic                        w_clr_ok;

    skew_ctrl #(
        .LINES (LINES),
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (bus.start),
        .busy       (w_busy),
        .last       (w_last),
        .lane_valid (w_lane_valid),
        .lane_elem  (w_lane_elem)
    );

    // Out-of-range indices are silently dropped; only a busy array flags an error.
    assign w_wr_ok  = bus.wr_en && !w_busy
                   && (int'(bus.wr_line) < LINES)
                   && (int'(bus.wr_elem) < DEPTH);
    assign w_clr_ok = bus.clr && !w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LINES; l++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[l][e] <= '0;
                end
            end
        end else begin
            if (w_clr_ok) begin
                for (int l = 0; l < LINES; l++) begin
                    for (int e = 0; e < DEPTH; e++) begin
                        r_mem[l][e] <= '0;
                    end
                end
            end
            if (w_wr_ok) begin
                r_mem[bus.wr_line][bus.wr_elem] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            r_data_out  <= '0;
            r_done      <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_out_valid <= w_lane_valid;
            r_done      <= w_last;
            r_wr_err    <= w_busy && (bus.wr_en || bus.clr);
            for (int i = 0; i < LINES; i++) begin
                if (w_lane_valid[i]) begin
                    r_data_out[i*DATA_WIDTH +: DATA_WIDTH] <= r_mem[i][w_lane_elem[i*c_elem_w +: c_elem_w]];
                end else begin
                    r_data_out[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
                end
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.wr_err    = r_wr_err;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_skew_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skew_buffer
// Description : Randomized and directed bench against a beat-queue reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skew_buffer;
    import mtpu_pkg::*;

    localparam int DW = 8;
    localparam int L  = 4;
    localparam int D  = 4;
    localparam int S  = L + D - 1;

    typedef struct packed {
        logic [L-1:0]    v;
        logic [L*DW-1:0] d;
        logic            last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    skew_buffer_if #(.DATA_WIDTH(DW), .LINES(L), .DEPTH(D)) bus ();

    skew_buffer #(.DATA_WIDTH(DW), .LINES(L), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t         q[$];
    logic [DW-1:0] m_mem [L][D];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Queue every beat of a stream from the array contents at the moment it starts.
    task automatic push_stream();
        beat_t b;
        for (int k = 0; k < S; k++) begin
            b = '0;
            for (int i = 0; i < L; i++) begin
                if (k - i >= 0 && k - i < D) begin
                    b.v[i]          = 1'b1;
                    b.d[i*DW +: DW] = m_mem[i][k-i];
                end
            end
            b.last = (k == S - 1);
            q.push_back(b);
        end
    endtask

    task automatic cycle(input bit we, input int ln, input int el, input logic [DW-1:0] wd,
                         input bit cl, input bit st);
        beat_t b;
        bit    was_busy;
        bit    err;
        @(negedge clk);
        bus.wr_en   = we;
        bus.wr_line = 2'(ln);
        bus.wr_elem = 2'(el);
        bus.wr_data = wd;
        bus.clr     = cl;
        bus.start   = st;
        @(posedge clk);
        was_busy = (q.size() > 0);
        b        = '0;
        if (was_busy) b = q.pop_front();
        err = was_busy && (we || cl);
        if (!was_busy) begin
            if (cl) begin
                for (int i = 0; i < L; i++)
                    for (int e = 0; e < D; e++) m_mem[i][e] = '0;
            end
            if (we && ln < L && el < D) m_mem[ln][el] = wd;
        end
        if (st && q.size() == 0) push_stream();
        #1;
        chk("busy",      64'(bus.busy),      64'(q.size() > 0));
        chk("done",      64'(bus.done),      64'(b.last));
        chk("wr_err",    64'(bus.wr_err),    64'(err));
        chk("out_valid", 64'(bus.out_valid), 64'(b.v));
        chk("data_out",  64'(bus.data_out),  64'(b.d));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.clr = 1'b0; bus.start = 1'b0;
        #1;
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        chk("rst_wr_err",    64'(bus.wr_err),    64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data_out",  64'(bus.data_out),  64'd0);
        q.delete();
        for (int i = 0; i < L; i++)
            for (int e = 0; e < D; e++) m_mem[i][e] = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nb;
        bus.wr_en = 1'b0; bus.wr_line = '0; bus.wr_elem = '0; bus.wr_data = '0;
        bus.clr = 1'b0; bus.start = 1'b0;
        for (int i = 0; i < L; i++)
            for (int e = 0; e < D; e++) m_mem[i][e] = '0;
        do_reset();

        // Load the reference pattern mem[i][e] = 16*i + e and stream it.
        for (int i = 0; i < L; i++)
            for (int e = 0; e < D; e++) cycle(1, i, e, 8'(16*i + e), 0, 0);
        nb = 0;
        cycle(0, 0, 0, 8'h00, 0, 1);
        nb += int'(bus.busy);
        for (int c = 1; c <= S; c++) begin
            cycle(0, 0, 0, 8'h00, 0, 0);
            nb += int'(bus.busy);
            if (c == 1) begin
                chk("b0_valid", 64'(bus.out_valid), 64'h1);
                chk("b0_line0", 64'(bus.data_out[7:0]), 64'h00);
            end
            if (c == 4) begin
                chk("b3_valid", 64'(bus.out_valid), 64'hF);
                chk("b3_data",  64'(bus.data_out),  64'h3021_1203);
            end
            if (c == 7) begin
                chk("b6_valid", 64'(bus.out_valid), 64'h8);
                chk("b6_data",  64'(bus.data_out),  64'h3300_0000);
                chk("b6_done",  64'(bus.done),      64'h1);
            end
        end
        chk("busy_cycles", 64'(nb), 64'd7);

        // Write attempted while streaming at step 2 is dropped.
        cycle(0, 0, 0, 8'h00, 0, 1);
        idle(2);
        cycle(1, 1, 2, 8'hAA, 0, 0);
        chk("busy_wr_err", 64'(bus.wr_err), 64'h1);
        idle(S);

        // Start alongside the final step chains a second stream without a gap beat.
        cycle(0, 0, 0, 8'h00, 0, 1);
        idle(S - 1);
        cycle(0, 0, 0, 8'h00, 0, 1);
        chk("chain_done", 64'(bus.done), 64'h1);
        cycle(0, 0, 0, 8'h00, 0, 0);
        chk("chain_b0_valid", 64'(bus.out_valid), 64'h1);
        chk("chain_b0_busy",  64'(bus.busy),      64'h1);
        idle(S);

        // Reset while the stream sits at step 3, then stream the cleared array.
        cycle(0, 0, 0, 8'h00, 0, 1);
        idle(3);
        do_reset();
        idle(2);
        cycle(0, 0, 0, 8'h00, 0, 1);
        idle(S + 1);

        // Clear, write and start in a single idle cycle.
        for (int n = 0; n < 6; n++)
            cycle(1, int'($urandom_range(0, L-1)), int'($urandom_range(0, D-1)), 8'($urandom), 0, 0);
        cycle(1, 2, 0, 8'h55, 1, 1);
        idle(2);
        cycle(0, 0, 0, 8'h00, 0, 0);
        chk("cws_b2_valid", 64'(bus.out_valid), 64'h7);
        chk("cws_b2_data",  64'(bus.data_out),  64'h0055_0000);
        idle(S);

        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 9) < 3,
                  int'($urandom_range(0, L-1)), int'($urandom_range(0, D-1)), 8'($urandom),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 2);
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        idle(S + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skew_buffer.md
SKEW_BUFFER -- requirements
Module: skew_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bit width of one stored element.
REQ-002 Parameter LINES, default 4, number of lines (output channels); SHALL be at least 2.
REQ-003 Parameter DEPTH, default 4, number of elements per line; SHALL be at least 2.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port wr_en  input  1  writes wr_data to mem[wr_line][wr_elem] when accepted.
REQ-007 Port wr_line  input  clog2(LINES)  line index for the write.
REQ-008 Port wr_elem  input  clog2(DEPTH)  element index for the write.
REQ-009 Port wr_data  input  DATA_WIDTH  write data.
REQ-010 Port clr  input  1  synchronous clear of all cells when accepted.
REQ-011 Port start  input  1  requests one skewed stream of the whole array.
REQ-012 Port busy  output  1  high while a stream is in progress.
REQ-013 Port done  output  1  one-cycle pulse coincident with the last stream beat.
REQ-014 Port wr_err  output  1  one-cycle pulse when a wr_en or clr is rejected.
REQ-015 Port out_valid  output  LINES  per-line valid for the current beat.
REQ-016 Port data_out  output  LINES*DATA_WIDTH  packed beat; line i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].

Function
REQ-017 Storage SHALL be a LINES x DEPTH array of DATA_WIDTH-bit cells.
REQ-018 Stream length is S = DEPTH+LINES-1 beats; FSM states are IDLE and STREAM.
REQ-019 In IDLE, start=1 at an edge SHALL move to STREAM with step counter = 0; start SHALL be ignored in STREAM.
REQ-020 In STREAM at step k, the edge SHALL register beat k: for each line i with e = k-i and 0 <= e < DEPTH, set out_valid[i]=1 and line i of data_out = mem[i][e]; otherwise set out_valid[i]=0 and line i = 0.
REQ-021 At step k = S-1 the FSM SHALL return to IDLE and register done=1 with that beat; otherwise step SHALL increment.
REQ-022 Outside STREAM-registered beats, out_valid and data_out SHALL be 0; done SHALL be high for exactly one cycle per stream.
REQ-023 busy SHALL equal (state == STREAM), so it is high for exactly S cycles, with beat k visible one cycle after step k.
REQ-024 wr_en in IDLE SHALL write at that edge; wr_en while busy SHALL be dropped and wr_err registered high for one cycle.
REQ-025 clr in IDLE SHALL zero every cell at that edge; clr while busy SHALL be dropped with wr_err; clr and wr_en together SHALL clear and then apply the write, leaving only that cell nonzero.
REQ-026 start together with wr_en/clr in IDLE SHALL accept both, and the stream SHALL read the updated contents.
REQ-027 start in the cycle where done=1 SHALL be accepted, giving back-to-back streams with no gap beat.
REQ-028 Out-of-range wr_line or wr_elem (when LINES or DEPTH is not a power of two) SHALL be ignored with no wr_err.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, step=0, all cells=0, and busy, done, wr_err, out_valid and data_out to 0, including mid-stream; no beat or done is issued for an aborted stream.

Structure
REQ-030 Package mtpu_pkg SHALL hold the DATA_WIDTH default and the FSM state enum (IDLE, STREAM).
REQ-031 Sub-module skew_ctrl SHALL hold the FSM, step counter and per-line element index/valid generation; storage and the output registers SHALL remain in skew_buffer.

Verification (LINES=4, DEPTH=4, DATA_WIDTH=8, mem[i][e] = 16*i+e)
REQ-032 Start from IDLE: beat0 valid=0001, line0=0x00; beat3 valid=1111, lines 0x03/0x12/0x21/0x30; beat6 valid=1000, line3=0x33 with done=1; busy high 7 cycles.
REQ-033 wr_en to [1][2]=0xAA during step 2: cell unchanged (still 0x12), wr_err pulses once, and the stream completes normally.
REQ-034 start raised again in the done cycle: second stream begins with no gap, and its beat0 line0=0x00 appears the cycle after beat6.
REQ-035 rst_n pulsed low at step 3: outputs go to 0 immediately, no done pulse; a new stream then returns all-zero data with the valid pattern per REQ-020.
REQ-036 clr plus wr_en [2][0]=0x55 plus start in one IDLE cycle: only line2 beat2 carries 0x55, and every other valid lane is 0x00.
